// File: rtl/mips_pkg.sv
// Shared types for the MIPS-lite pipeline control logic: writer slots, forwarding
// selects and the hazard scheduler's drain FSM.
package mips_pkg;

  localparam int unsigned REGISTERWIDTH = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } sched_state_t;

  typedef struct packed {
    logic                     valid;
    logic [REGISTERWIDTH-1:0] rd;
    logic                     regWrite;
    logic                     memRead;
  } writer_slot_t;

  // The youngest producer wins: EX/MEM holds newer data than MEM/WB.
  function automatic fwd_sel_t fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex) return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode-side control bundle between the ID stage and the hazard scheduler.
interface hazard_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  import mips_pkg::*;

  logic                     id_valid;
  logic [REGISTERWIDTH-1:0] id_rs1;
  logic [REGISTERWIDTH-1:0] id_rs2;
  logic                     id_uses_rs1;
  logic                     id_uses_rs2;
  logic [REGISTERWIDTH-1:0] id_rd;
  logic                     id_regWrite;
  logic                     id_memRead;
  logic                     id_halt;
  logic                     ex_branch_taken;

  logic                     stall_if_id;
  logic                     bubble_ex;
  logic                     flush_if_id;
  fwd_sel_t                 fwd_a;
  fwd_sel_t                 fwd_b;
  logic                     halted;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regWrite, id_memRead, id_halt, ex_branch_taken,
    input  stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, halted, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regWrite, id_memRead, id_halt, ex_branch_taken,
    output stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, halted, stall_count
  );

endinterface

// File: rtl/hazard_match.sv
// Compares one in-flight writer slot against one ID source operand.
module hazard_match
  import mips_pkg::*;
(
  input  writer_slot_t              slot_i,
  input  logic [REGISTERWIDTH-1:0]  src_i,
  input  logic                      uses_i,
  output logic                      match_o,
  output logic                      load_match_o
);

  // r0 is hardwired zero, so it never carries a dependency.
  assign match_o = slot_i.valid && slot_i.regWrite && (slot_i.rd != '0) &&
                   (slot_i.rd == src_i) && uses_i;
  assign load_match_o = match_o && slot_i.memRead;

endmodule

// File: rtl/hazard_scheduler.sv
// ID-stage sequencer: tracks EX/MEM/WB writers, raises stall/bubble/flush, registers
// EX forwarding selects, drains the pipe on HALT and counts stall cycles.
module hazard_scheduler
  import mips_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scheduler_if.slave  bus
);

  // With bypassing only a load still in EX cannot be satisfied; without it every slot counts.
  localparam logic [2:0] StallWin = FWD_EN ? 3'b001 : 3'b111;

  writer_slot_t     ex_q, mem_q, wb_q, ex_d;
  sched_state_t     state_q, state_d;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  writer_slot_t     slots [3];
  logic [2:0]       m_rs1, m_rs2, ld_rs1, ld_rs2;
  logic             hazard, issue;
  logic             stall, bubble, flush;

  assign slots[0] = ex_q;
  assign slots[1] = mem_q;
  assign slots[2] = wb_q;

  for (genvar i = 0; i < 3; i++) begin : g_match
    hazard_match u_rs1 (
      .slot_i       (slots[i]),
      .src_i        (bus.id_rs1),
      .uses_i       (bus.id_uses_rs1),
      .match_o      (m_rs1[i]),
      .load_match_o (ld_rs1[i])
    );
    hazard_match u_rs2 (
      .slot_i       (slots[i]),
      .src_i        (bus.id_rs2),
      .uses_i       (bus.id_uses_rs2),
      .match_o      (m_rs2[i]),
      .load_match_o (ld_rs2[i])
    );
  end

  assign hazard = bus.id_valid &&
                  (|((FWD_EN ? (ld_rs1 | ld_rs2) : (m_rs1 | m_rs2)) & StallWin));

  always_comb begin
    state_d = state_q;
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    issue   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.ex_branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hazard) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          issue = bus.id_valid;
        end
      end
      DRAIN: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (!(ex_q.valid || mem_q.valid || wb_q.valid)) state_d = HALTED;
      end
      HALTED: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (issue) begin
      // HALT moves down the pipe as an empty slot so it never looks like a writer.
      if (bus.id_halt) begin
        state_d = DRAIN;
      end else begin
        ex_d = '{valid: 1'b1, rd: bus.id_rd, regWrite: bus.id_regWrite,
                 memRead: bus.id_memRead};
      end
      if (FWD_EN) begin
        fwd_a_d = fwd_pick(m_rs1[0], m_rs1[1]);
        fwd_b_d = fwd_pick(m_rs2[0], m_rs2[1]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_if_id = stall;
  assign bus.bubble_ex   = bubble;
  assign bus.flush_if_id = flush;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: a forwarding instance (16-bit counter) and a
// non-forwarding instance (4-bit counter) share the ID stimulus.
module tb_hazard_scheduler;
  import mips_pkg::*;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr, halt, br;
  } stim_t;

  typedef struct {
    int          id;
    bit          dsel;
    logic        st, bu, fl;
    logic [1:0]  fa, fb;
    logic        hl;
    logic [15:0] cnt;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  stim_t cur;
  exp_t  sb [$];
  exp_t  mon_e;
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc_n = 0;

  hazard_scheduler_if #(.CNT_W(16)) bus1 ();
  hazard_scheduler_if #(.CNT_W(4))  bus0 ();

  hazard_scheduler #(.FWD_EN(1'b1), .CNT_W(16)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  hazard_scheduler #(.FWD_EN(1'b0), .CNT_W(4))  u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  assign bus1.id_valid = cur.v;            assign bus0.id_valid = cur.v;
  assign bus1.id_rs1 = cur.rs1;            assign bus0.id_rs1 = cur.rs1;
  assign bus1.id_rs2 = cur.rs2;            assign bus0.id_rs2 = cur.rs2;
  assign bus1.id_uses_rs1 = cur.u1;        assign bus0.id_uses_rs1 = cur.u1;
  assign bus1.id_uses_rs2 = cur.u2;        assign bus0.id_uses_rs2 = cur.u2;
  assign bus1.id_rd = cur.rd;              assign bus0.id_rd = cur.rd;
  assign bus1.id_regWrite = cur.rw;        assign bus0.id_regWrite = cur.rw;
  assign bus1.id_memRead = cur.mr;         assign bus0.id_memRead = cur.mr;
  assign bus1.id_halt = cur.halt;          assign bus0.id_halt = cur.halt;
  assign bus1.ex_branch_taken = cur.br;    assign bus0.ex_branch_taken = cur.br;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic stim_t nop();
    stim_t s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2);
    stim_t s = nop();
    s.v = 1'b1; s.rd = rd; s.rw = 1'b1;
    s.rs1 = rs1; s.u1 = 1'b1; s.rs2 = rs2; s.u2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    stim_t s = nop();
    s.v = 1'b1; s.rd = rd; s.rw = 1'b1; s.mr = 1'b1; s.rs1 = rs1; s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t hlt();
    stim_t s = nop();
    s.v = 1'b1; s.halt = 1'b1;
    return s;
  endfunction

  function automatic stim_t with_br(input stim_t s);
    stim_t r = s;
    r.br = 1'b1;
    return r;
  endfunction

  function automatic exp_t x(input bit dsel, input logic st, input logic bu, input logic fl,
                             input logic [1:0] fa, input logic [1:0] fb, input logic hl,
                             input logic [15:0] cnt);
    exp_t e;
    e.id = 0; e.dsel = dsel; e.st = st; e.bu = bu; e.fl = fl;
    e.fa = fa; e.fb = fb; e.hl = hl; e.cnt = cnt;
    return e;
  endfunction

  // One clock: present ID stimulus and queue what that cycle's outputs must be.
  task automatic cyc(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    cur = s;
    e.id = cyc_n++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      if (mon_e.dsel) begin
        check($sformatf("c%0d.d1.stall", mon_e.id), 32'(bus1.stall_if_id), 32'(mon_e.st));
        check($sformatf("c%0d.d1.bubble", mon_e.id), 32'(bus1.bubble_ex), 32'(mon_e.bu));
        check($sformatf("c%0d.d1.flush", mon_e.id), 32'(bus1.flush_if_id), 32'(mon_e.fl));
        check($sformatf("c%0d.d1.fwd_a", mon_e.id), 32'(bus1.fwd_a), 32'(mon_e.fa));
        check($sformatf("c%0d.d1.fwd_b", mon_e.id), 32'(bus1.fwd_b), 32'(mon_e.fb));
        check($sformatf("c%0d.d1.halted", mon_e.id), 32'(bus1.halted), 32'(mon_e.hl));
        check($sformatf("c%0d.d1.count", mon_e.id), 32'(bus1.stall_count), 32'(mon_e.cnt));
      end else begin
        check($sformatf("c%0d.d0.stall", mon_e.id), 32'(bus0.stall_if_id), 32'(mon_e.st));
        check($sformatf("c%0d.d0.bubble", mon_e.id), 32'(bus0.bubble_ex), 32'(mon_e.bu));
        check($sformatf("c%0d.d0.flush", mon_e.id), 32'(bus0.flush_if_id), 32'(mon_e.fl));
        check($sformatf("c%0d.d0.fwd_a", mon_e.id), 32'(bus0.fwd_a), 32'(mon_e.fa));
        check($sformatf("c%0d.d0.fwd_b", mon_e.id), 32'(bus0.fwd_b), 32'(mon_e.fb));
        check($sformatf("c%0d.d0.halted", mon_e.id), 32'(bus0.halted), 32'(mon_e.hl));
        check($sformatf("c%0d.d0.count", mon_e.id), 32'(bus0.stall_count), 32'(mon_e.cnt));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, ".d1.stall"}, 32'(bus1.stall_if_id), 32'h0);
    check({tag, ".d1.bubble"}, 32'(bus1.bubble_ex), 32'h0);
    check({tag, ".d1.flush"}, 32'(bus1.flush_if_id), 32'h0);
    check({tag, ".d1.fwd_a"}, 32'(bus1.fwd_a), 32'h0);
    check({tag, ".d1.fwd_b"}, 32'(bus1.fwd_b), 32'h0);
    check({tag, ".d1.halted"}, 32'(bus1.halted), 32'h0);
    check({tag, ".d1.count"}, 32'(bus1.stall_count), 32'h0);
    check({tag, ".d0.stall"}, 32'(bus0.stall_if_id), 32'h0);
    check({tag, ".d0.halted"}, 32'(bus0.halted), 32'h0);
    check({tag, ".d0.count"}, 32'(bus0.stall_count), 32'h0);
  endtask

  // Pull reset between clock edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    cur = nop();
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] ec;
    cur = nop();
    #1 reset = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b1;

    // Load-use: one stall, then bypass from MEM/WB.
    cyc(lw(5, 1),       x(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(alu(6, 5, 2),   x(1, 1, 1, 0, 0, 0, 0, 0));
    cyc(alu(6, 5, 2),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 2, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 0, 0, 0, 1));
    // Back-to-back ALU dependency on rs2: EX/MEM bypass.
    cyc(alu(3, 1, 4),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(alu(7, 1, 3),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 0, 1, 0, 1));
    // One NOP between: MEM/WB bypass.
    cyc(alu(3, 1, 2),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(alu(9, 1, 3),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 0, 2, 0, 1));
    // Producer writes r0: no bypass.
    cyc(alu(0, 1, 2),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(alu(9, 1, 0),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 0, 0, 0, 1));
    // Both EX and MEM write r3: EX/MEM wins.
    cyc(alu(3, 1, 2),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(alu(3, 1, 2),   x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(alu(10, 3, 1),  x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 0, 0, 0, 1, 0, 0, 1));
    // Branch beats load-use; branch also suppresses a HALT in ID.
    cyc(lw(5, 1),                 x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(with_br(alu(6, 5, 2)),    x(1, 0, 1, 1, 0, 0, 0, 1));
    cyc(nop(),                    x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(with_br(hlt()),           x(1, 0, 1, 1, 0, 0, 0, 1));
    cyc(nop(),                    x(1, 0, 0, 0, 0, 0, 0, 1));
    // HALT behind two writers: drain, then halted three edges after issue.
    cyc(alu(11, 1, 2),  x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(alu(12, 1, 2),  x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(hlt(),          x(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 1, 1, 0, 0, 0, 0, 1));
    cyc(alu(13, 1, 2),  x(1, 1, 1, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 1, 1, 0, 0, 0, 0, 1));
    cyc(nop(),          x(1, 1, 1, 0, 0, 0, 1, 1));
    cyc(alu(13, 12, 2), x(1, 1, 1, 0, 0, 0, 1, 1));
    async_reset("rst_halted");
    cyc(nop(),          x(1, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a drain leaves nothing behind.
    cyc(alu(11, 1, 2),  x(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(alu(12, 1, 2),  x(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(hlt(),          x(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(nop(),          x(1, 1, 1, 0, 0, 0, 0, 0));
    async_reset("rst_drain");
    cyc(nop(),          x(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(alu(14, 1, 2),  x(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(nop(),          x(1, 0, 0, 0, 0, 0, 0, 0));

    // No forwarding: every RAW waits three cycles; 4-bit counter saturates at 15.
    async_reset("rst_nofwd");
    ec = 16'd0;
    for (int r = 0; r < 6; r++) begin
      cyc(alu(7, 1, 2), x(0, 0, 0, 0, 0, 0, 0, ec));
      for (int k = 0; k < 3; k++) begin
        cyc(alu(8, 7, 2), x(0, 1, 1, 0, 0, 0, 0, ec));
        ec = (ec == 16'd15) ? 16'd15 : ec + 16'd1;
      end
      cyc(alu(8, 7, 2), x(0, 0, 0, 0, 0, 0, 0, ec));
    end
    cyc(nop(),          x(0, 0, 0, 0, 0, 0, 0, 16'd15));
    cyc(nop(),          x(0, 0, 0, 0, 0, 0, 0, 16'd15));

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
